// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 32-bit pipeline.
//
// Computes the ALU result for the instruction held in the ID/EX register and
// registers it, together with store data and memory/writeback control, into
// the EX/MEM boundary. An optional iterative shift-add multiplier (one bit of
// the multiplier per cycle) stalls upstream via ex_busy while it runs and
// sends bubbles downstream until the product is ready.
//
// Build option:
//   EX_MUL_UNIT_EN  defined   -> multiplier + IDLE/BUSY FSM present, MUL takes
//                                33 cycles from acceptance to result.
//                   undefined -> no multiplier; alu_op 12 yields 0 in 1 cycle,
//                                ex_busy is tied low.
//
// Ports:
//   clk, rst (sync, active-low)
//   ex_valid, alu_op[3:0], opA/opB[31:0], store_data[31:0],
//   ex_write_En, ex_read_En, ex_Mem_WB[1:0], ex_dest[4:0], flush  (inputs)
//   ex_busy                                  stall request to upstream
//   DataAddress, WriteData, write_En, read_En, Mem_WB, dest  (EX/MEM regs)
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  alu_op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] store_data,
  input  logic        ex_write_En,
  input  logic        ex_read_En,
  input  logic [1:0]  ex_Mem_WB,
  input  logic [4:0]  ex_dest,
  input  logic        flush,
  output logic        ex_busy,
  output logic [31:0] DataAddress,
  output logic [31:0] WriteData,
  output logic        write_En,
  output logic        read_En,
  output logic [1:0]  Mem_WB,
  output logic [4:0]  dest
);

  // The counter compare and the 6-bit counter assume exactly 32 iterations.
  if (MUL_CYCLES != 32) begin : g_bad_mul_cycles
    $error("ex_stage: MUL_CYCLES must be 32");
  end

  // -------------------------------------------------------------------------
  // Single-cycle ALU
  // -------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  assign shamt = opB[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = opA + opB;
      4'd1:    alu_res = opA - opB;
      4'd2:    alu_res = opA & opB;
      4'd3:    alu_res = opA | opB;
      4'd4:    alu_res = opA ^ opB;
      4'd5:    alu_res = ~(opA | opB);
      4'd6:    alu_res = {31'd0, ($signed(opA) < $signed(opB))};
      4'd7:    alu_res = {31'd0, (opA < opB)};
      4'd8:    alu_res = opA << shamt;
      4'd9:    alu_res = opA >> shamt;
      4'd10:   alu_res = $unsigned($signed(opA) >>> shamt);
      4'd11:   alu_res = {opB[15:0], 16'd0};
      // 12 (MUL) is produced by the multiplier path; 13..15 are undefined.
      default: alu_res = '0;
    endcase
  end

  // Load selects for the EX/MEM register (flush and reset handled below).
  logic        take_alu;
  logic        take_mul;
  logic [31:0] mul_res;

`ifdef EX_MUL_UNIT_EN
  // -------------------------------------------------------------------------
  // Iterative shift-add multiplier
  // -------------------------------------------------------------------------
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam int unsigned CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      acc_sum;
  logic             mul_start;
  logic             mul_last;
  logic             busy_raw;

  assign mul_start = ex_valid & (alu_op == OP_MUL) & ~flush;
  // Accumulator value after this cycle's iteration; on the last iteration
  // this is the finished product.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign mul_res   = acc_sum;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy_raw = 1'b0;
    mul_last = 1'b0;
    take_alu = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_raw = mul_start;
        take_alu = ex_valid & ~mul_start;
        if (mul_start) begin
          state_d  = S_BUSY;
          mcand_d  = opA;
          mplier_d = opB;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_BUSY: begin
        // The final iteration runs while ex_busy is already low, so upstream
        // advances on the same edge that captures the product.
        busy_raw = (cnt_q != CNT_LAST);
        mul_last = (cnt_q == CNT_LAST);
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // An abort wins over everything, including the final iteration.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign take_mul = mul_last;
  // Reset gates the stall so upstream is never held while in reset.
  assign ex_busy  = rst & busy_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`else
  // No multiplier: every valid instruction (MUL included) is a 1-cycle op.
  assign take_alu = ex_valid;
  assign take_mul = 1'b0;
  assign mul_res  = '0;
  assign ex_busy  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // EX/MEM register
  // -------------------------------------------------------------------------
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [1:0]  mem_wb_q, mem_wb_d;
  logic [4:0]  dest_q, dest_d;

  always_comb begin
    // Default is a bubble.
    addr_d   = '0;
    wdata_d  = '0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    mem_wb_d = '0;
    dest_d   = '0;
    if (!flush && (take_alu || take_mul)) begin
      addr_d   = take_mul ? mul_res : alu_res;
      wdata_d  = store_data;
      we_d     = ex_write_En;
      re_d     = ex_read_En;
      mem_wb_d = ex_Mem_WB;
      dest_d   = ex_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      mem_wb_q <= '0;
      dest_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      mem_wb_q <= mem_wb_d;
      dest_q   <= dest_d;
    end
  end

  assign DataAddress = addr_q;
  assign WriteData   = wdata_q;
  assign write_En    = we_q;
  assign read_En     = re_q;
  assign Mem_WB      = mem_wb_q;
  assign dest        = dest_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// Directed ALU table, hand-written reset/flush/multiply sequences and a
// randomized instruction stream checked against a transaction-level model.
// Works with and without EX_MUL_UNIT_EN defined.
// ---------------------------------------------------------------------------
module tb_ex_stage;

`ifdef EX_MUL_UNIT_EN
  localparam bit MUL_EN = 1'b1;
  localparam logic [31:0] EXP_M1   = 32'h00060003;
  localparam logic [31:0] EXP_WRAP = 32'h00000001;
  localparam logic [31:0] EXP_6    = 32'd6;
  localparam logic [31:0] EXP_20   = 32'd20;
`else
  localparam bit MUL_EN = 1'b0;
  localparam logic [31:0] EXP_M1   = 32'd0;
  localparam logic [31:0] EXP_WRAP = 32'd0;
  localparam logic [31:0] EXP_6    = 32'd0;
  localparam logic [31:0] EXP_20   = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  alu_op;
  logic [31:0] opA, opB, store_data;
  logic        ex_write_En, ex_read_En;
  logic [1:0]  ex_Mem_WB;
  logic [4:0]  ex_dest;
  logic        flush;
  logic        ex_busy;
  logic [31:0] DataAddress, WriteData;
  logic        write_En, read_En;
  logic [1:0]  Mem_WB;
  logic [4:0]  dest;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_op(alu_op),
    .opA(opA), .opB(opB), .store_data(store_data),
    .ex_write_En(ex_write_En), .ex_read_En(ex_read_En),
    .ex_Mem_WB(ex_Mem_WB), .ex_dest(ex_dest), .flush(flush),
    .ex_busy(ex_busy), .DataAddress(DataAddress), .WriteData(WriteData),
    .write_En(write_En), .read_En(read_En), .Mem_WB(Mem_WB), .dest(dest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        we;
    logic        re;
    logic [1:0]  wb;
    logic [4:0]  dst;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [1:0]  wb;
    logic [4:0]  dst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } out_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam out_t BUBBLE = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference ALU from the operation definitions.
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return $unsigned($signed(a) >>> sh);
      4'd11: return b * 32'd65536;
`ifdef EX_MUL_UNIT_EN
      4'd12: return a * b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic stim_t mk(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] dst);
    stim_t s;
    s.valid = 1'b1;
    s.op    = op;
    s.a     = a;
    s.b     = b;
    s.sd    = a ^ 32'hA5A5_0F0F;
    s.we    = dst[0];
    s.re    = dst[1];
    s.wb    = dst[3:2];
    s.dst   = dst;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ex_valid    = s.valid;
    alu_op      = s.op;
    opA         = s.a;
    opB         = s.b;
    store_data  = s.sd;
    ex_write_En = s.we;
    ex_read_En  = s.re;
    ex_Mem_WB   = s.wb;
    ex_dest     = s.dst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input logic exp, input string nm);
    n_cmp++;
    if (ex_busy !== exp) begin
      n_bad++;
      $display("FAIL %s ex_busy: got %0b required %0b (t=%0t)", nm, ex_busy, exp, $time);
    end
  endtask

  task automatic chk_out(input out_t exp, input string nm);
    out_t got;
    got = {write_En, read_En, Mem_WB, dest, DataAddress, WriteData};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s outputs {we,re,wb,dest,addr,wdata}: got %0b,%0b,%0d,%0d,%h,%h required %0b,%0b,%0d,%0d,%h,%h (t=%0t)",
               nm, got.we, got.re, got.wb, got.dst, got.addr, got.wdata,
               exp.we, exp.re, exp.wb, exp.dst, exp.addr, exp.wdata, $time);
    end
  endtask

  // Present one instruction and hold it for as long as the stage stalls:
  // a MUL (when the multiplier exists) stalls 32 cycles and its result shows
  // up after the 33rd edge; everything else completes after one edge.
  task automatic run_instr(input stim_t s, input logic [31:0] exp_res, input string nm);
    int   extra;
    out_t exp_o;
    extra = (MUL_EN && s.valid && s.op == 4'd12) ? 32 : 0;
    exp_o = BUBBLE;
    if (s.valid) begin
      exp_o.we    = s.we;
      exp_o.re    = s.re;
      exp_o.wb    = s.wb;
      exp_o.dst   = s.dst;
      exp_o.addr  = exp_res;
      exp_o.wdata = s.sd;
    end
    flush = 1'b0;
    drive(s);
    for (int k = 0; k <= extra; k++) begin
      #1;
      chk_busy(k < extra, nm);
      tick();
      if (k == extra) chk_out(exp_o, nm);
      else            chk_out(BUBBLE, nm);
    end
    $display("txn %s valid=%0b op=%0d a=%h b=%h -> DataAddress=%h dest=%0d cycles=%0d",
             nm, s.valid, s.op, s.a, s.b, DataAddress, dest, extra + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[17];
    stim_t s;

    // ---------------- reset ----------------
    rst   = 1'b0;
    flush = 1'b0;
    drive(mk(4'd0, 32'd5, 32'd7, 5'd3));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_busy(1'b0, "reset");
      tick();
      chk_out(BUBBLE, "reset");
    end
    $display("txn reset held 3 cycles");
    rst = 1'b1;
    run_instr(mk(4'd0, 32'd5, 32'd7, 5'd9), 32'd12, "rst_add");

    // ---------------- directed ALU table ----------------
    vecs[0]  = '{4'd1,  32'd3,         32'd5,         32'hFFFFFFFE};
    vecs[1]  = '{4'd6,  32'hFFFFFFFF,  32'd1,         32'd1};
    vecs[2]  = '{4'd7,  32'hFFFFFFFF,  32'd1,         32'd0};
    vecs[3]  = '{4'd10, 32'h80000000,  32'd4,         32'hF8000000};
    vecs[4]  = '{4'd11, 32'hDEADBEEF,  32'h00001234,  32'h12340000};
    vecs[5]  = '{4'd2,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000};
    vecs[6]  = '{4'd3,  32'hF0F0F0F0,  32'h0F0F0000,  32'hFFFFF0F0};
    vecs[7]  = '{4'd4,  32'hFFFF0000,  32'h0FF00FF0,  32'hF00F0FF0};
    vecs[8]  = '{4'd5,  32'h0000FFFF,  32'h00FF0000,  32'hFF000000};
    vecs[9]  = '{4'd8,  32'h00000003,  32'h00000021,  32'h00000006};
    vecs[10] = '{4'd9,  32'h80000000,  32'd31,        32'h00000001};
    vecs[11] = '{4'd0,  32'hFFFFFFFF,  32'd2,         32'h00000001};
    vecs[12] = '{4'd13, 32'd1,         32'd2,         32'd0};
    vecs[13] = '{4'd15, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0};
    vecs[14] = '{4'd10, 32'h7FFFFFFF,  32'd4,         32'h07FFFFFF};
    vecs[15] = '{4'd6,  32'd1,         32'hFFFFFFFF,  32'd0};
    vecs[16] = '{4'd7,  32'd1,         32'hFFFFFFFF,  32'd1};
    for (int i = 0; i < 17; i++) begin
      run_instr(mk(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1)), vecs[i].exp,
                $sformatf("vec%0d", i));
    end

    // ---------------- multiply ----------------
    run_instr(mk(4'd12, 32'h00010001, 32'h00030003, 5'd17), EXP_M1, "mul_basic");
    run_instr(mk(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22), EXP_WRAP, "mul_wrap");
    run_instr(mk(4'd12, 32'd2, 32'd3, 5'd5), EXP_6, "mul_b2b_1");
    run_instr(mk(4'd12, 32'd4, 32'd5, 5'd6), EXP_20, "mul_b2b_2");

    // ---------------- flush in IDLE (MUL not accepted, ALU killed) -------
    flush = 1'b1;
    drive(mk(4'd12, 32'd2, 32'd3, 5'd5));
    #1;
    chk_busy(1'b0, "flush_mul_idle");
    tick();
    chk_out(BUBBLE, "flush_mul_idle");
    drive(mk(4'd0, 32'd1, 32'd1, 5'd5));
    #1;
    chk_busy(1'b0, "flush_alu");
    tick();
    chk_out(BUBBLE, "flush_alu");
    $display("txn flush with MUL and ADD in idle");
    s = mk(4'd0, 32'd0, 32'd0, 5'd0);
    s.valid = 1'b0;
    run_instr(s, 32'd0, "idle_after_flush");

`ifdef EX_MUL_UNIT_EN
    // ---------------- flush at N+10 of a MUL ----------------
    flush = 1'b0;
    drive(mk(4'd12, 32'h00010001, 32'h00030003, 5'd7));
    for (int k = 0; k < 10; k++) begin
      #1;
      chk_busy(1'b1, "flush_mul_run");
      tick();
      chk_out(BUBBLE, "flush_mul_run");
    end
    flush = 1'b1;
    #1;
    chk_busy(1'b1, "flush_mul_cycle");
    tick();
    chk_out(BUBBLE, "flush_abort");
    $display("txn MUL flushed at N+10");
    run_instr(mk(4'd0, 32'd100, 32'd23, 5'd4), 32'd123, "post_flush_add");

    // ---------------- reset mid-multiply ----------------
    drive(mk(4'd12, 32'd9, 32'd9, 5'd8));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_busy(1'b1, "rst_mul_run");
      tick();
      chk_out(BUBBLE, "rst_mul_run");
    end
    rst = 1'b0;
    #1;
    chk_busy(1'b0, "rst_mul_gate");
    tick();
    chk_out(BUBBLE, "rst_mul_abort");
    rst = 1'b1;
    $display("txn MUL aborted by reset");
    run_instr(s, 32'd0, "idle_after_rst");
    run_instr(mk(4'd1, 32'd50, 32'd8, 5'd11), 32'd42, "post_rst_sub");
`endif

    // ---------------- randomized stream vs. model ----------------
    for (int i = 0; i < 150; i++) begin
      stim_t r;
      r.valid = ($urandom_range(0, 7) != 0);
      r.op    = 4'($urandom_range(0, 15));
      r.a     = $urandom;
      r.b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r.sd    = $urandom;
      r.we    = 1'($urandom_range(0, 1));
      r.re    = 1'($urandom_range(0, 1));
      r.wb    = 2'($urandom_range(0, 3));
      r.dst   = 5'($urandom_range(0, 31));
      run_instr(r, ref_result(r.op, r.a, r.b), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 32-bit pipeline. Takes decoded operands and control from the ID/EX register, computes the ALU result, and registers the result into the EX/MEM boundary that drives the memory stage (`DataAddress`, `WriteData`, `write_En`, `read_En`, `Mem_WB`, `dest`). Includes an iterative 32-cycle shift-add multiplier. While the multiplier runs, the block stalls upstream and sends bubbles downstream.

## Interface

Parameters:
- `MUL_CYCLES`, default 32: number of multiplier iterations. Fixed at 32; the parameter only sizes the counter (6 bits).

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, **synchronous, active-low**.
- `ex_valid`, input, 1: the ID/EX register holds a real instruction.
- `alu_op`, input, 4: operation select.
- `opA`, `opB`, input, 32 each: ALU operands.
- `store_data`, input, 32: store value.
- `ex_write_En`, `ex_read_En`, input, 1 each: memory write/read requests.
- `ex_Mem_WB`, input, 2: writeback control bits.
- `ex_dest`, input, 5: destination register.
- `flush`, input, 1: kill the current instruction.
- `ex_busy`, output, 1: stall request; upstream holds ID/EX while high.
- `DataAddress`, `WriteData`, output, 32 each: registered ALU result and store data.
- `write_En`, `read_En`, output, 1 each: registered memory enables.
- `Mem_WB`, output, 2: registered writeback control.
- `dest`, output, 5: registered destination register.

## Operation

`alu_op` encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT: signed compare, result 1 or 0. 7 SLTU: unsigned compare.
- 8 SLL, 9 SRL, 10 SRA: shift amount is `opB[4:0]`.
- 11 LUI: `opB<<16`.
- 12 MUL: low 32 bits of the product.
- 13–15: result 0.
- All arithmetic wraps modulo 2^32; no overflow flag.

State machine, states IDLE and BUSY:
- **IDLE → BUSY** when `ex_valid & alu_op==12 & !flush`.
  - Latch `opA` as the multiplicand and `opB` as the multiplier.
  - Clear the accumulator; counter = 0.
- **In BUSY, each cycle:**
  - If `mplier[0]`, add `mcand` to `acc` (32-bit wrap).
  - Shift `mcand` left by 1 and `mplier` right by 1.
  - Increment the counter.
- **BUSY → IDLE** when the counter reaches 31 on this update, i.e. on the 32nd iteration.
  - Load the EX/MEM register with `acc` (including that iteration's addition), `store_data`, the enables, `Mem_WB` and `dest`.
- `ex_busy` = (IDLE & `ex_valid` & op==MUL & !`flush`) | (BUSY & counter≠31). This is combinational.

EX/MEM register load rules, in priority order:
1. `!rst`: bubble.
2. `flush`: bubble; state forced to IDLE, counter cleared.
3. `ex_busy` high: bubble.
4. BUSY final cycle: multiply result.
5. IDLE & `ex_valid`: ALU result.
6. Otherwise: bubble.

Bubble = `write_En`=0, `read_En`=0, `Mem_WB`=0, `dest`=0, `DataAddress`=0, `WriteData`=0.

## Timing

- Reset value of every output is 0, with state IDLE. `ex_busy` is 0 during reset because the state is IDLE and the reset term gates it.
- ALU ops: 1-cycle latency. Operands present in cycle N appear on outputs in cycle N+1.
- MUL accepted in cycle N:
  - `ex_busy` is high in cycles N..N+31 and low in N+32.
  - Bubbles are emitted in cycles N+1..N+32.
  - The result appears in cycle N+33.
  - Upstream advances at the end of cycle N+32.
- Upstream must hold every ID/EX input stable while `ex_busy` is high. The latched multiplier operands make this tolerant, but `store_data`/`dest`/control are sampled in the final cycle.
- `flush` mid-multiply: the next edge aborts, emits a bubble, and returns to IDLE. The result is discarded.
- `flush` together with a new MUL in IDLE: the MUL is not accepted and `ex_busy` stays 0.
- `rst` low mid-multiply: same as flush, and outputs are forced to 0.
- Back-to-back MULs: the second is accepted in cycle N+33, the first IDLE cycle, so `ex_busy` drops for exactly one cycle (N+32).

## Configuration

- `EX_MUL_UNIT_EN` defined: multiplier and BUSY state present, as above.
- `EX_MUL_UNIT_EN` undefined:
  - No multiplier logic or counter.
  - `alu_op` 12 behaves as an undefined op: result 0, 1-cycle latency.
  - `ex_busy` is tied to 0.
  - `MUL_CYCLES` is unused.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles with `ex_valid`=1, ADD → all outputs 0, `ex_busy`=0. Release → ADD 5+7 gives `DataAddress`=12 next cycle.
- **ALU sweep:**
  - SUB 3−5 → 0xFFFFFFFE.
  - SLT(−1, 1) → 1.
  - SLTU(0xFFFFFFFF, 1) → 0.
  - SRA(0x80000000, 4) → 0xF8000000.
  - LUI(0x1234) → 0x12340000.
- **MUL** 0x10001 × 0x30003 → `ex_busy` high for exactly 32 cycles, 32 bubbles, then `DataAddress`=0x00060003 in cycle N+33 with the correct `dest`/`Mem_WB`.
- **Wrap multiply:** 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- **Flush at cycle N+10 of a MUL** → bubble next cycle, `ex_busy`=0. A following ADD issued in N+11 completes normally in N+12.
- **Back-to-back MULs** (2×3, then 4×5) → results 6 at N+33 and 20 at N+66. With `EX_MUL_UNIT_EN` undefined, the same stimulus gives 0 and 0 at 1-cycle latency and `ex_busy` never asserts.
